// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Holds the controller state encoding and the hardwired-zero register id.
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   localparam logic [3:0] ZERO_REG = 4'h0;
endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Pure combinational; writes to the zero register never create a hazard.
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [3:0] rs,
   input  logic [3:0] rt,
   input  logic       rs_used,
   input  logic       rt_used,
   input  logic [3:0] rd,
   input  logic       register_we,
   input  logic       memory_en,
   input  logic       memory_we,
   output logic       load_use
);
   logic is_load;
   logic rs_hit;
   logic rt_hit;

   assign is_load  = memory_en & ~memory_we & register_we;
   assign rs_hit   = rs_used & (rs == rd);
   assign rt_hit   = rt_used & (rt == rd);
   assign load_use = is_load & (rd != ZERO_REG) & (rs_hit | rt_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: pipeline register enables, bubbles, halt drain
// sequencing and saturating stall/bubble performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       rs_ID,
   input  logic [3:0]       rt_ID,
   input  logic             rs_used_ID,
   input  logic             rt_used_ID,
   input  logic [3:0]       rd_EX,
   input  logic             register_we_EX,
   input  logic             memory_en_EX,
   input  logic             memory_we_EX,
   input  logic             branch_taken_ID,
   input  logic             halt_ID,
   input  logic             halt_WB,
   input  logic             icache_miss,
   input  logic             dcache_miss,
   output logic             pc_we,
   output logic             IF_ID_we,
   output logic             ID_EX_we,
   output logic             EX_MEM_we,
   output logic             MEM_WB_we,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             MEM_WB_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count
);
   state_t state;
   logic   load_use;
   logic   active;
   logic   go_drain;
   logic   stall_inc;
   logic   bubble_inc;

   load_use_detect u_lud (
      .rs          (rs_ID),
      .rt          (rt_ID),
      .rs_used     (rs_used_ID),
      .rt_used     (rt_used_ID),
      .rd          (rd_EX),
      .register_we (register_we_EX),
      .memory_en   (memory_en_EX),
      .memory_we   (memory_we_EX),
      .load_use    (load_use)
   );

   assign active = (state != HALTED);

   always_comb begin
      pc_we        = active;
      IF_ID_we     = active;
      ID_EX_we     = active;
      EX_MEM_we    = active;
      MEM_WB_we    = active;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      MEM_WB_flush = 1'b0;
      go_drain     = 1'b0;
      if (state == DRAIN) begin
         pc_we       = 1'b0;
         IF_ID_flush = 1'b1;
      end
      if (active && dcache_miss) begin
         pc_we        = 1'b0;
         IF_ID_we     = 1'b0;
         ID_EX_we     = 1'b0;
         EX_MEM_we    = 1'b0;
         MEM_WB_flush = 1'b1;
      end else if (state == RUN) begin
         priority case (1'b1)
            load_use: begin
               pc_we       = 1'b0;
               IF_ID_we    = 1'b0;
               ID_EX_flush = 1'b1;
            end
            icache_miss && branch_taken_ID: begin
               pc_we       = 1'b0;
               IF_ID_we    = 1'b0;
               ID_EX_flush = 1'b1;
            end
            icache_miss: begin
               pc_we       = 1'b0;
               IF_ID_flush = 1'b1;
            end
            branch_taken_ID: IF_ID_flush = 1'b1;
            halt_ID: begin
               pc_we       = 1'b0;
               IF_ID_flush = 1'b1;
               go_drain    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign stall_inc  = active & ~pc_we;
   assign bubble_inc = IF_ID_flush | ID_EX_flush | MEM_WB_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         halted       <= 1'b0;
         stall_cycles <= '0;
         bubble_count <= '0;
      end else begin
         // WB commits even while MEM is stalled, so halt_WB wins over dcache_miss
         unique case (state)
            RUN: begin
               if (halt_WB) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end else if (go_drain) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (halt_WB) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: halted <= 1'b1;
            default: state <= RUN;
         endcase
         if (stall_inc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (bubble_inc && (bubble_count != '1))
            bubble_count <= bubble_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: decode vector table plus
// multi-cycle sequences, checked through an expected-result queue.
module tb_pipeline_ctrl;
   typedef struct packed {
      logic [3:0] rs;
      logic [3:0] rt;
      logic       rsu;
      logic       rtu;
      logic [3:0] rd;
      logic [2:0] kind;
      logic       br;
      logic       hid;
      logic       hwb;
      logic       im;
      logic       dm;
      logic       rst;
   } in_t;

   typedef struct packed {
      logic [7:0]  ctl;
      logic        hlt;
      logic        chk;
      logic [15:0] st;
      logic [15:0] bc;
   } exp_t;

   typedef struct packed {
      in_t        i;
      logic [7:0] ctl;
   } vec_t;

   localparam logic [7:0] DEF  = 8'b11111_000;
   localparam logic [7:0] DC   = 8'b00001_001;
   localparam logic [7:0] LU   = 8'b00111_010;
   localparam logic [7:0] IC   = 8'b01111_100;
   localparam logic [7:0] BR   = 8'b11111_100;
   localparam logic [7:0] DRN  = 8'b01111_100;
   localparam logic [7:0] DRDC = 8'b00001_101;
   localparam logic [7:0] HLT  = 8'b00000_000;
   localparam logic [2:0] LD   = 3'b110;
   localparam logic [2:0] ST   = 3'b011;
   localparam logic [2:0] ALU  = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rs_ID, rt_ID, rd_EX;
   logic        rs_used_ID, rt_used_ID;
   logic        register_we_EX, memory_en_EX, memory_we_EX;
   logic        branch_taken_ID, halt_ID, halt_WB;
   logic        icache_miss, dcache_miss;
   logic        pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we;
   logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, halted;
   logic [15:0] stall_cycles, bubble_count;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t e;
   logic [7:0] act;
   vec_t tbl[14];

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .rs_ID(rs_ID), .rt_ID(rt_ID),
      .rs_used_ID(rs_used_ID), .rt_used_ID(rt_used_ID),
      .rd_EX(rd_EX), .register_we_EX(register_we_EX),
      .memory_en_EX(memory_en_EX), .memory_we_EX(memory_we_EX),
      .branch_taken_ID(branch_taken_ID),
      .halt_ID(halt_ID), .halt_WB(halt_WB),
      .icache_miss(icache_miss), .dcache_miss(dcache_miss),
      .pc_we(pc_we), .IF_ID_we(IF_ID_we), .ID_EX_we(ID_EX_we),
      .EX_MEM_we(EX_MEM_we), .MEM_WB_we(MEM_WB_we),
      .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
      .MEM_WB_flush(MEM_WB_flush), .halted(halted),
      .stall_cycles(stall_cycles), .bubble_count(bubble_count)
   );

   function automatic in_t mk(input logic [3:0] rs, input logic rsu,
                              input logic [3:0] rt, input logic rtu,
                              input logic [3:0] rd, input logic [2:0] kind,
                              input logic br, input logic hid,
                              input logic hwb, input logic im,
                              input logic dm, input logic r);
      in_t t;
      t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
      t.rd = rd; t.kind = kind; t.br = br; t.hid = hid;
      t.hwb = hwb; t.im = im; t.dm = dm; t.rst = r;
      return t;
   endfunction

   function automatic exp_t ex(input logic [7:0] ctl, input logic hlt,
                               input logic chk, input int st,
                               input int bc);
      exp_t t;
      t.ctl = ctl; t.hlt = hlt; t.chk = chk;
      t.st = st[15:0]; t.bc = bc[15:0];
      return t;
   endfunction

   task automatic apply(input in_t i);
      rs_ID = i.rs; rs_used_ID = i.rsu;
      rt_ID = i.rt; rt_used_ID = i.rtu;
      rd_EX = i.rd;
      {register_we_EX, memory_en_EX, memory_we_EX} = i.kind;
      branch_taken_ID = i.br; halt_ID = i.hid; halt_WB = i.hwb;
      icache_miss = i.im; dcache_miss = i.dm; rst = i.rst;
   endtask

   task automatic step(input in_t i, input exp_t x);
      @(posedge clk);
      #1;
      apply(i);
      q.push_back(x);
   endtask

   task automatic idle_step(input in_t i);
      @(posedge clk);
      #1;
      apply(i);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         act = {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we,
                IF_ID_flush, ID_EX_flush, MEM_WB_flush};
         checks++;
         if (act !== e.ctl) begin
            failures++;
            $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
         end
         checks++;
         if (halted !== e.hlt) begin
            failures++;
            $display("FAIL halted t=%0t got=%b want=%b", $time, halted, e.hlt);
         end
         if (e.chk) begin
            checks++;
            if (stall_cycles !== e.st) begin
               failures++;
               $display("FAIL stall_cycles t=%0t got=%h want=%h",
                        $time, stall_cycles, e.st);
            end
            checks++;
            if (bubble_count !== e.bc) begin
               failures++;
               $display("FAIL bubble_count t=%0t got=%h want=%h",
                        $time, bubble_count, e.bc);
            end
         end
      end
   end

   initial begin
      in_t I, R;
      I = mk(0,0,0,0,0,3'b000,0,0,0,0,0,0);
      R = mk(0,0,0,0,0,3'b000,0,0,0,0,0,1);
      apply(R);

      // decode table, applied with rst held so state stays RUN
      tbl[0]  = '{mk(0,0,0,0,0,3'b000,0,0,0,0,0,1), DEF};
      tbl[1]  = '{mk(3,1,0,0,3,LD,0,0,0,0,0,1), LU};
      tbl[2]  = '{mk(3,0,0,0,3,LD,0,0,0,0,0,1), DEF};
      tbl[3]  = '{mk(0,0,3,1,3,LD,0,0,0,0,0,1), LU};
      tbl[4]  = '{mk(0,1,0,0,0,LD,0,0,0,0,0,1), DEF};
      tbl[5]  = '{mk(3,1,0,0,3,ST,0,0,0,0,0,1), DEF};
      tbl[6]  = '{mk(3,1,0,0,3,3'b010,0,0,0,0,0,1), DEF};
      tbl[7]  = '{mk(3,1,0,0,3,LD,1,1,0,0,0,1), LU};
      tbl[8]  = '{mk(3,1,0,0,3,LD,1,0,0,1,1,1), DC};
      tbl[9]  = '{mk(0,0,0,0,0,3'b000,1,0,0,1,0,1), LU};
      tbl[10] = '{mk(0,0,0,0,0,3'b000,0,0,0,1,0,1), IC};
      tbl[11] = '{mk(0,0,0,0,0,3'b000,1,1,0,0,0,1), BR};
      tbl[12] = '{mk(0,0,0,0,0,3'b000,0,1,0,0,0,1), IC};
      tbl[13] = '{mk(5,1,5,1,5,ALU,0,0,0,0,0,1), DEF};

      repeat (2) idle_step(R);
      for (int k = 0; k < 14; k++)
         step(tbl[k].i, ex(tbl[k].ctl, 0, 0, 0, 0));
      idle_step(R);

      // load-use bubble, then load to R0
      step(mk(3,1,0,0,3,LD,0,0,0,0,0,0), ex(LU, 0, 1, 0, 0));
      step(I, ex(DEF, 0, 1, 1, 1));
      step(mk(0,1,0,0,0,LD,0,0,0,0,0,0), ex(DEF, 0, 1, 1, 1));
      step(I, ex(DEF, 0, 1, 1, 1));

      // dcache miss over load-use
      idle_step(R);
      for (int k = 0; k < 3; k++)
         step(mk(3,1,0,0,3,LD,0,0,0,0,1,0), ex(DC, 0, 1, k, k));
      step(mk(3,1,0,0,3,LD,0,0,0,0,0,0), ex(LU, 0, 1, 3, 3));
      step(I, ex(DEF, 0, 1, 4, 4));

      // icache miss with branch waiting in ID
      idle_step(R);
      step(mk(0,0,0,0,0,3'b000,1,0,0,1,0,0), ex(LU, 0, 1, 0, 0));
      step(mk(0,0,0,0,0,3'b000,1,0,0,1,0,0), ex(LU, 0, 1, 1, 1));
      step(mk(0,0,0,0,0,3'b000,1,0,0,0,0,0), ex(BR, 0, 1, 2, 2));
      step(I, ex(DEF, 0, 1, 2, 3));

      // halt drain, dcache miss together with halt_WB, then reset
      idle_step(R);
      step(mk(0,0,0,0,0,3'b000,0,1,0,0,0,0), ex(IC, 0, 1, 0, 0));
      step(I, ex(DRN, 0, 1, 1, 1));
      step(mk(3,1,0,0,3,LD,1,0,0,1,0,0), ex(DRN, 0, 1, 2, 2));
      step(mk(0,0,0,0,0,3'b000,0,0,1,0,1,0), ex(DRDC, 0, 1, 3, 3));
      step(mk(0,0,0,0,0,3'b000,1,0,0,1,1,0), ex(HLT, 1, 1, 4, 4));
      step(I, ex(HLT, 1, 1, 4, 4));
      step(R, ex(HLT, 1, 1, 4, 4));
      step(I, ex(DEF, 0, 1, 0, 0));

      // halt_WB seen while still in RUN
      step(mk(0,0,0,0,0,3'b000,0,0,1,0,0,0), ex(DEF, 0, 1, 0, 0));
      step(I, ex(HLT, 1, 1, 0, 0));

      // counter saturation via a long icache miss
      idle_step(R);
      for (int k = 0; k < 65534; k++)
         idle_step(mk(0,0,0,0,0,3'b000,0,0,0,1,0,0));
      step(mk(0,0,0,0,0,3'b000,0,0,0,1,0,0), ex(IC, 0, 1, 65534, 65534));
      step(mk(0,0,0,0,0,3'b000,0,0,0,1,0,0), ex(IC, 0, 1, 65535, 65535));
      step(mk(0,0,0,0,0,3'b000,0,0,0,1,0,0), ex(IC, 0, 1, 65535, 65535));
      step(I, ex(DEF, 0, 1, 65535, 65535));

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
